// File: rtl/vx_commit_arb_if.sv
// vx_commit_arb_if: commit stream handshake; data = {cu_id[2], uuid[16], wid[4], tmask, pc[32], wb, rd[5], lane data, pid, sop, eop}, eop at bit 0
interface vx_commit_arb_if #(
  parameter int NUM_LANES = 4,
  parameter int PID_WIDTH = 1
);
  localparam int DATA_W = 2 + 16 + 4 + NUM_LANES + 32 + 1 + 5 + NUM_LANES * 32 + PID_WIDTH + 2;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;
  modport master (output valid, data, input ready);
  modport slave (input valid, data, output ready);
endinterface

// File: rtl/vx_commit_arb.sv
// vx_commit_arb: round-robin merge of commit streams keeping multi-beat packets contiguous, one registered output slot
module vx_commit_arb #(
  parameter int NUM_REQS  = 4,
  parameter int NUM_LANES = 4,
  parameter int PID_WIDTH = 1,
  parameter int CTR_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  vx_commit_arb_if.slave   commit_in_if [NUM_REQS],
  vx_commit_arb_if.master  commit_out_if,
  output logic [CTR_W-1:0] perf_commits
);
  localparam int DATA_W = 2 + 16 + 4 + NUM_LANES + 32 + 1 + 5 + NUM_LANES * 32 + PID_WIDTH + 2;
  localparam int IDX_W  = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] lock_idx, lock_idx_n, rr_ptr, rr_ptr_n, cand, idx;
  logic [NUM_REQS-1:0] in_valid;
  logic [DATA_W-1:0] in_data [NUM_REQS];
  logic [DATA_W-1:0] out_data;
  logic out_valid, enq_ok, accept, found, eop_in;
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_in
    assign in_valid[i] = commit_in_if[i].valid;
    assign in_data[i] = commit_in_if[i].data;
    assign commit_in_if[i].ready = reset && enq_ok && (cand == IDX_W'(i));
  end
  assign enq_ok = !out_valid || commit_out_if.ready;
  assign accept = reset && enq_ok && in_valid[cand];
  assign eop_in = in_data[cand][0];
  assign commit_out_if.valid = out_valid;
  assign commit_out_if.data = out_data;
  // candidate: the locked source, otherwise the first valid source at or after rr_ptr
  always_comb begin
    cand = rr_ptr;
    idx = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQS);
      if (!found && in_valid[idx]) begin
        cand = idx;
        found = 1'b1;
      end
    end
    if (state == LOCKED) cand = lock_idx;
  end
  // lock on a non-final beat; an eop beat releases the lock and moves the pointer past the winner
  always_comb begin
    state_n = state;
    lock_idx_n = lock_idx;
    rr_ptr_n = rr_ptr;
    if (accept) begin
      state_n = eop_in ? IDLE : LOCKED;
      lock_idx_n = eop_in ? lock_idx : cand;
      rr_ptr_n = !eop_in ? rr_ptr : (cand == IDX_W'(NUM_REQS - 1)) ? '0 : cand + 1'b1;
    end
  end
  // arbitration state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      lock_idx <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_n;
      lock_idx <= lock_idx_n;
      rr_ptr <= rr_ptr_n;
    end
  end
  // output slot: load on accept, empty on drain, hold under backpressure; count eop handshakes
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      perf_commits <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data <= in_data[cand];
      end else if (commit_out_if.ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && commit_out_if.ready && out_data[0]) perf_commits <= perf_commits + 1'b1;
    end
  end
endmodule

// File: tb/tb_vx_commit_arb.sv
// tb_vx_commit_arb: randomized scenarios against a cycle-level reference model of the commit arbiter
module tb_vx_commit_arb;
  localparam int NR = 4;
  localparam int NL = 4;
  localparam int PW = 1;
  localparam int CW = 4;
  localparam int DW = 2 + 16 + 4 + NL + 32 + 1 + 5 + NL * 32 + PW + 2;
  typedef logic [DW-1:0] beat_t;
  typedef struct { beat_t d; int dly; } item_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic out_ready = 1'b0;
  logic [NR-1:0] src_valid = '0;
  logic [NR-1:0] src_ready;
  logic [NR-1:0] last_ready;
  beat_t src_data [NR];
  logic [CW-1:0] perf;
  item_t srcq [NR][$];
  int waitc [NR];
  beat_t obs [$];
  beat_t expq [$];
  bit m_locked, m_ov;
  int m_lock, m_ptr, m_cnt;
  beat_t m_od;
  int mm, checks, errors;
  always #5 clk = ~clk;
  vx_commit_arb_if #(.NUM_LANES(NL), .PID_WIDTH(PW)) in_if [NR] ();
  vx_commit_arb_if #(.NUM_LANES(NL), .PID_WIDTH(PW)) out_if ();
  for (genvar i = 0; i < NR; i++) begin : g_src
    assign in_if[i].valid = src_valid[i];
    assign in_if[i].data = src_data[i];
    assign src_ready[i] = in_if[i].ready;
  end
  assign out_if.ready = out_ready;
  vx_commit_arb #(.NUM_REQS(NR), .NUM_LANES(NL), .PID_WIDTH(PW), .CTR_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .commit_in_if(in_if),
    .commit_out_if(out_if),
    .perf_commits(perf)
  );
  function automatic int tag(beat_t b);
    return int'(b[DW-1 -: 2]);
  endfunction
  function automatic beat_t make_beat(int s, int pid, bit sop, bit eop);
    beat_t b;
    for (int k = 0; k < DW; k++) b[k] = 1'($urandom);
    b[0] = eop;
    b[1] = sop;
    b[2 +: PW] = PW'(pid);
    b[DW-1 -: 2] = 2'(s);
    return b;
  endfunction
  function automatic bit busy();
    bit b = m_ov;
    for (int i = 0; i < NR; i++) if (srcq[i].size() > 0) b = 1'b1;
    return b;
  endfunction
  function automatic int qdiff();
    int d = obs.size() > expq.size() ? obs.size() - expq.size() : expq.size() - obs.size();
    for (int k = 0; k < obs.size() && k < expq.size(); k++) if (obs[k] !== expq[k]) d++;
    return d;
  endfunction
  task automatic push(input int s, input beat_t d, input int dly);
    srcq[s].push_back('{d: d, dly: dly});
  endtask
  task automatic clear_src();
    for (int i = 0; i < NR; i++) begin
      srcq[i].delete();
      src_valid[i] = 1'b0;
      waitc[i] = 0;
    end
  endtask
  // one clock: present source beats, predict grant/readies/output, advance model and sources
  task automatic cycle(input bit ordy);
    int cand;
    bit enq, acc, found;
    beat_t acc_d;
    logic [NR-1:0] pop;
    for (int i = 0; i < NR; i++)
      if (!src_valid[i] && srcq[i].size() > 0) begin
        if (waitc[i] >= srcq[i][0].dly) begin
          src_valid[i] = 1'b1;
          src_data[i] = srcq[i][0].d;
        end else waitc[i]++;
      end
    out_ready = ordy;
    #1;
    cand = m_ptr;
    found = 1'b0;
    if (m_locked) cand = m_lock;
    else for (int k = 0; k < NR; k++)
      if (!found && src_valid[(m_ptr + k) % NR]) begin
        cand = (m_ptr + k) % NR;
        found = 1'b1;
      end
    enq = !m_ov || ordy;
    acc = (reset === 1'b1) && enq && src_valid[cand];
    acc_d = src_data[cand];
    for (int i = 0; i < NR; i++) if (src_ready[i] !== ((reset === 1'b1) && enq && i == cand)) mm++;
    if (out_if.valid !== m_ov || (m_ov && out_if.data !== m_od) || perf !== CW'(m_cnt)) mm++;
    if (out_if.valid === 1'b1 && ordy) obs.push_back(out_if.data);
    if (m_ov && ordy) expq.push_back(m_od);
    last_ready = src_ready;
    pop = src_valid & src_ready;
    @(posedge clk);
    @(negedge clk);
    if (reset !== 1'b1) begin
      m_locked = 0; m_lock = 0; m_ptr = 0; m_ov = 0; m_od = '0; m_cnt = 0;
    end else begin
      if (m_ov && ordy && m_od[0]) m_cnt++;
      if (acc) begin
        m_ov = 1'b1;
        m_od = acc_d;
        if (acc_d[0]) begin
          m_locked = 1'b0;
          m_ptr = (cand + 1) % NR;
        end else begin
          m_locked = 1'b1;
          m_lock = cand;
        end
      end else if (ordy) m_ov = 1'b0;
    end
    for (int i = 0; i < NR; i++)
      if (pop[i] === 1'b1) begin
        void'(srcq[i].pop_front());
        src_valid[i] = 1'b0;
        waitc[i] = 0;
      end
  endtask
  task automatic drain(input int maxc, input int pct, output int n);
    n = 0;
    while (n < maxc && busy()) begin
      cycle($urandom_range(99) < pct);
      n++;
    end
  endtask
  task automatic do_reset();
    clear_src();
    reset = 1'b0;
    cycle(1'b1);
    cycle(1'b1);
    reset = 1'b1;
    obs.delete();
    expq.delete();
    mm = 0;
  endtask
  task automatic test_reset();
    for (int s = 0; s < NR; s++) push(s, make_beat(s, 0, 1, 1), 0);
    reset = 1'b0;
    cycle(1'b1);
    mm = 0;
    cycle(1'b1);
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_if.valid); end
    checks++; if (out_if.data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_if.data); end
    checks++; if (perf !== '0) begin errors++; $display("FAIL reset_perf: got %0d want 0", perf); end
    checks++; if (last_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0000", last_ready); end
    checks++; if (mm !== 0) begin errors++; $display("FAIL reset_model: mismatches %0d want 0", mm); end
    clear_src();
    reset = 1'b1;
  endtask
  task automatic test_round_robin();
    int n, bad;
    do_reset();
    for (int r = 0; r < 2; r++) for (int s = 0; s < NR; s++) push(s, make_beat(s, 0, 1, 1), 0);
    drain(50, 100, n);
    bad = 0;
    for (int k = 0; k < obs.size(); k++) if (tag(obs[k]) != k % NR) bad++;
    checks++; if (obs.size() != 8 || bad != 0) begin errors++; $display("FAIL rr_order: beats %0d misordered %0d want 8 and 0", obs.size(), bad); end
    checks++; if (n != 9) begin errors++; $display("FAIL rr_throughput: cycles %0d want 9", n); end
    checks++; if (perf !== CW'(8)) begin errors++; $display("FAIL rr_perf: got %0d want 8", perf); end
    checks++; if (mm !== 0 || qdiff() != 0) begin errors++; $display("FAIL rr_model: mismatches %0d diffs %0d want 0", mm, qdiff()); end
  endtask
  task automatic test_packet_lock();
    int n, bad;
    int exp_t [4] = '{1, 1, 1, 2};
    do_reset();
    push(1, make_beat(1, 0, 1, 0), 0);
    push(1, make_beat(1, 1, 0, 0), 1);
    push(1, make_beat(1, 2, 0, 1), 0);
    push(2, make_beat(2, 0, 1, 1), 0);
    cycle(1'b1);
    cycle(1'b1);
    checks++; if (last_ready[2] !== 1'b0) begin errors++; $display("FAIL lock_idle_ready2: got %b want 0", last_ready[2]); end
    cycle(1'b1);
    cycle(1'b1);
    checks++; if (dut.rr_ptr !== 2'd2) begin errors++; $display("FAIL lock_rr_ptr: got %0d want 2", dut.rr_ptr); end
    drain(50, 100, n);
    bad = 0;
    for (int k = 0; k < obs.size() && k < 4; k++) if (tag(obs[k]) != exp_t[k]) bad++;
    checks++; if (obs.size() != 4 || bad != 0) begin errors++; $display("FAIL lock_order: beats %0d misordered %0d want 4 and 0", obs.size(), bad); end
    checks++; if (mm !== 0 || qdiff() != 0) begin errors++; $display("FAIL lock_model: mismatches %0d diffs %0d want 0", mm, qdiff()); end
  endtask
  task automatic test_backpressure();
    int n;
    beat_t first;
    do_reset();
    first = make_beat(0, 0, 1, 1);
    push(0, first, 0);
    for (int s = 1; s < NR; s++) push(s, make_beat(s, 0, 1, 1), 0);
    for (int s = 0; s < NR; s++) push(s, make_beat(s, 0, 1, 1), 0);
    cycle(1'b1);
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0);
      checks++; if (out_if.valid !== 1'b1 || out_if.data !== first) begin errors++; $display("FAIL bp_hold[%0d]: valid %b data %h want 1 %h", c, out_if.valid, out_if.data, first); end
      checks++; if (last_ready !== '0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, last_ready); end
    end
    drain(200, 70, n);
    checks++; if (obs.size() != 8) begin errors++; $display("FAIL bp_count: beats %0d want 8", obs.size()); end
    checks++; if (mm !== 0 || qdiff() != 0) begin errors++; $display("FAIL bp_model: mismatches %0d diffs %0d want 0", mm, qdiff()); end
  endtask
  task automatic test_pointer_wrap();
    int n, bad;
    int exp_t [3] = '{3, 0, 3};
    do_reset();
    push(3, make_beat(3, 0, 1, 1), 0);
    push(3, make_beat(3, 0, 1, 1), 0);
    push(0, make_beat(0, 0, 1, 1), 1);
    drain(50, 100, n);
    bad = 0;
    for (int k = 0; k < obs.size() && k < 3; k++) if (tag(obs[k]) != exp_t[k]) bad++;
    checks++; if (obs.size() != 3 || bad != 0) begin errors++; $display("FAIL wrap_order: beats %0d misordered %0d want 3 and 0", obs.size(), bad); end
    checks++; if (mm !== 0) begin errors++; $display("FAIL wrap_model: mismatches %0d want 0", mm); end
  endtask
  task automatic test_reset_mid_packet();
    beat_t b2;
    do_reset();
    push(0, make_beat(0, 0, 1, 0), 0);
    push(0, make_beat(0, 1, 0, 1), 0);
    cycle(1'b1);
    reset = 1'b0;
    clear_src();
    cycle(1'b1);
    checks++; if (out_if.valid !== 1'b0 || perf !== '0) begin errors++; $display("FAIL midrst_state: valid %b perf %0d want 0 0", out_if.valid, perf); end
    reset = 1'b1;
    b2 = make_beat(2, 0, 1, 1);
    push(2, b2, 0);
    cycle(1'b1);
    checks++; if (last_ready[2] !== 1'b1) begin errors++; $display("FAIL midrst_grant2: ready %b want 1", last_ready[2]); end
    checks++; if (out_if.valid !== 1'b1 || out_if.data !== b2) begin errors++; $display("FAIL midrst_out: valid %b data %h want 1 %h", out_if.valid, out_if.data, b2); end
    checks++; if (mm !== 0) begin errors++; $display("FAIL midrst_model: mismatches %0d want 0", mm); end
  endtask
  task automatic test_counter_wrap();
    int n;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      int s = $urandom_range(NR - 1);
      push(s, make_beat(s, 0, 1, 1), $urandom_range(2));
    end
    drain(500, 70, n);
    checks++; if (n >= 500) begin errors++; $display("FAIL ctr_timeout: cycles %0d want < 500", n); end
    checks++; if (perf !== CW'(1)) begin errors++; $display("FAIL ctr_wrap: got %0d want 1", perf); end
    checks++; if (mm !== 0 || qdiff() != 0) begin errors++; $display("FAIL ctr_model: mismatches %0d diffs %0d want 0", mm, qdiff()); end
  endtask
  task automatic test_random_packets();
    int n, bad, gap;
    beat_t sent [NR][$];
    int idx [NR];
    do_reset();
    for (int s = 0; s < NR; s++) begin
      idx[s] = 0;
      for (int p = 0, np = $urandom_range(2, 5); p < np; p++) begin
        int len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          beat_t d = make_beat(s, b, b == 0, b == len - 1);
          push(s, d, $urandom_range(2));
          sent[s].push_back(d);
        end
      end
    end
    drain(3000, 60, n);
    checks++; if (n >= 3000) begin errors++; $display("FAIL rand_timeout: cycles %0d want < 3000", n); end
    checks++; if (mm !== 0 || qdiff() != 0) begin errors++; $display("FAIL rand_model: mismatches %0d diffs %0d want 0", mm, qdiff()); end
    bad = 0;
    for (int k = 0; k < obs.size(); k++) begin
      int t = tag(obs[k]);
      if (idx[t] >= sent[t].size() || obs[k] !== sent[t][idx[t]]) bad++;
      idx[t]++;
    end
    for (int s = 0; s < NR; s++) if (idx[s] != sent[s].size()) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_per_source: lost/reordered %0d want 0", bad); end
    gap = 0;
    for (int k = 0; k < obs.size(); k++)
      if (obs[k][0] == 1'b0 && (k + 1 >= obs.size() || tag(obs[k + 1]) != tag(obs[k]))) gap++;
    checks++; if (gap != 0) begin errors++; $display("FAIL rand_contiguous: split packets %0d want 0", gap); end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    mm = 0;
    for (int i = 0; i < NR; i++) begin
      src_data[i] = '0;
      waitc[i] = 0;
    end
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_pointer_wrap();
    test_reset_mid_packet();
    test_counter_wrap();
    test_random_packets();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
